// File: rtl/cdb_pkg.sv
// Shared types and default sizing for the common data bus producer.
// The broadcaster takes its parameter defaults from here.
package cdb_pkg;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    // Advance an index by one, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr_i, wrapping modulo NUM_REQ. Also used by the issue-select logic.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_grant_o
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NUM_REQ);

    // cand_idx[k] is the k-th index visited when scanning from ptr_i.
    logic [IDX_W-1:0] cand_idx [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, ptr_i} + (IDX_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_grant_o && req_i[cand_idx[k]]) begin
                any_grant_o          = 1'b1;
                grant_idx_o          = cand_idx[k];
                grant_o[cand_idx[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB producer: one holding buffer per functional unit, round-robin select,
// and a registered (tag, data, src) broadcast of one result per cycle.
module cdb_broadcaster #(
    parameter  int NUM_FU = cdb_pkg::NUM_FU,
    parameter  int TAG_W  = cdb_pkg::TAG_W,
    parameter  int DATA_W = cdb_pkg::DATA_W,
    localparam int SRC_W  = $clog2(NUM_FU)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           flush_in,
    input  logic [NUM_FU-1:0]              fu_valid_in,
    input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag_in,
    input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data_in,
    output logic [NUM_FU-1:0]              fu_ready_out,
    output logic                           cdb_valid_out,
    output logic [TAG_W-1:0]               cdb_tag_out,
    output logic [DATA_W-1:0]              cdb_data_out,
    output logic [SRC_W-1:0]               cdb_src_out
);

    import cdb_pkg::*;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

    logic [NUM_FU-1:0] full_q, full_d;
    buf_entry_t        buf_q [NUM_FU];
    buf_entry_t        buf_d [NUM_FU];
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic [NUM_FU-1:0] grant;
    logic [SRC_W-1:0]  grant_idx;
    logic              any_grant;
    logic [NUM_FU-1:0] accept;
    logic              fire;

    rr_arbiter #(
        .NUM_REQ (NUM_FU)
    ) u_arb (
        .req_i       (full_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    // A granted buffer empties this edge, so it may be refilled in the same cycle.
    assign fu_ready_out = ~full_q | grant;
    assign accept       = fu_valid_in & fu_ready_out;
    assign fire         = any_grant & ~flush_in;

    always_comb begin
        full_d = full_q;
        for (int i = 0; i < NUM_FU; i++) begin
            buf_d[i] = buf_q[i];
            if (flush_in) begin
                full_d[i] = 1'b0;
            end else if (accept[i]) begin
                full_d[i]     = 1'b1;
                buf_d[i].tag  = fu_tag_in[i];
                buf_d[i].data = fu_data_in[i];
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        cdb_valid_d = fire;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (fire) begin
            cdb_tag_d  = buf_q[grant_idx].tag;
            cdb_data_d = buf_q[grant_idx].data;
            cdb_src_d  = grant_idx;
            rr_ptr_d   = SRC_W'(wrap_inc(int'(grant_idx), NUM_FU));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            full_q      <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            full_q      <= full_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            for (int i = 0; i < NUM_FU; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign cdb_valid_out = cdb_valid_q;
    assign cdb_tag_out   = cdb_tag_q;
    assign cdb_data_out  = cdb_data_q;
    assign cdb_src_out   = cdb_src_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: stimulus queues the expected broadcasts,
// a negedge monitor pops and compares each one the DUT presents.
module tb_cdb_broadcaster;

    import cdb_pkg::*;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [3:0]        fu_valid;
    logic [3:0][3:0]   fu_tag;
    logic [3:0][31:0]  fu_data;
    logic [3:0]        fu_ready;
    logic              cdb_valid;
    logic [3:0]        cdb_tag;
    logic [31:0]       cdb_data;
    logic [1:0]        cdb_src;

    typedef struct {
        logic [1:0] src;
        cdb_entry_t ent;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    cdb_broadcaster #(.NUM_FU(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .flush_in      (flush),
        .fu_valid_in   (fu_valid),
        .fu_tag_in     (fu_tag),
        .fu_data_in    (fu_data),
        .fu_ready_out  (fu_ready),
        .cdb_valid_out (cdb_valid),
        .cdb_tag_out   (cdb_tag),
        .cdb_data_out  (cdb_data),
        .cdb_src_out   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_bcast(input logic [1:0] s, input logic [3:0] t, input logic [31:0] d);
        exp_t e;
        e.src      = s;
        e.ent.tag  = t;
        e.ent.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every broadcast must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && cdb_valid) begin
            $display("[TB] bcast src=%0d tag=%0d data=%08h", cdb_src, cdb_tag, cdb_data);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bcast: got src=%0d tag=%0d data=%08h, required none",
                         cdb_src, cdb_tag, cdb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bcast_src", 64'(cdb_src), 64'(e.src));
                check("bcast_tag", 64'(cdb_tag), 64'(e.ent.tag));
                check("bcast_data", 64'(cdb_data), 64'(e.ent.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hs;
        int na;
        int nb;

        rst      = 1'b0;
        flush    = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;

        // Reset asserted mid-cycle before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_tag", 64'(cdb_tag), 64'd0);
        check("rst_data", 64'(cdb_data), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 64'(fu_ready), 64'hF);

        // Single result from FU1
        fu_valid = 4'b0010; fu_tag[1] = 4'd3; fu_data[1] = 32'h0000_0005;
        expect_bcast(2'd1, 4'd3, 32'h5);
        step();
        fu_valid = '0;
        check("single_no_early_bcast", 64'(cdb_valid), 64'd0);
        step();
        check("single_bcast_valid", 64'(cdb_valid), 64'd1);
        check("single_rr_ptr", 64'(dut.rr_ptr_q), 64'd2);
        step();
        check("single_idle", 64'(cdb_valid), 64'd0);

        // FU3 result brings rr_ptr back to 0
        fu_valid = 4'b1000; fu_tag[3] = 4'd7; fu_data[3] = 32'h77;
        expect_bcast(2'd3, 4'd7, 32'h77);
        step();
        fu_valid = '0;
        step();
        step();
        check("ptr_zero", 64'(dut.rr_ptr_q), 64'd0);

        // All four at once, FU0 refilled while being granted
        fu_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i]  = 4'(i);
            fu_data[i] = 32'h100 + 32'(i);
            expect_bcast(2'(i), 4'(i), 32'h100 + 32'(i));
        end
        expect_bcast(2'd0, 4'd4, 32'h200);
        step();
        check("all4_ready_fu0_only", 64'(fu_ready), 64'b0001);
        fu_valid = 4'b0001; fu_tag[0] = 4'd4; fu_data[0] = 32'h200;
        step();
        fu_valid = '0;
        check("all4_bcast0", 64'(cdb_valid), 64'd1);
        for (int i = 1; i < 5; i++) begin
            step();
            check("all4_consecutive", 64'(cdb_valid), 64'd1);
        end
        step();
        check("all4_idle", 64'(cdb_valid), 64'd0);

        // Continuous contention FU0/FU2, rr_ptr=1: order FU2,FU0,FU2,...
        for (int k = 0; k < 10; k++) begin
            expect_bcast(2'd2, 4'(8 + k % 8), 32'hB000 + 32'(k));
            expect_bcast(2'd0, 4'(k % 8), 32'hA000 + 32'(k));
        end
        expect_bcast(2'd2, 4'd10, 32'hB00A);
        na = 0;
        nb = 0;
        for (int c = 0; c < 20; c++) begin
            fu_valid   = 4'b0101;
            fu_tag[0]  = 4'(na % 8);
            fu_data[0] = 32'hA000 + 32'(na);
            fu_tag[2]  = 4'(8 + nb % 8);
            fu_data[2] = 32'hB000 + 32'(nb);
            #1;
            hs = fu_valid & fu_ready;
            step();
            if (hs[0]) na++;
            if (hs[2]) nb++;
        end
        fu_valid = '0;
        repeat (3) step();
        check("contend_fu0_accepts", 64'(na), 64'd10);
        check("contend_fu2_accepts", 64'(nb), 64'd11);
        check("contend_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure on FU3 (rr_ptr=3 here)
        fu_valid = 4'b0010; fu_tag[1] = 4'd6; fu_data[1] = 32'h66;
        expect_bcast(2'd1, 4'd6, 32'h66);
        step();
        fu_valid = 4'b1100;
        fu_tag[2] = 4'd9;  fu_data[2] = 32'h99;
        fu_tag[3] = 4'd10; fu_data[3] = 32'hD1D1;
        expect_bcast(2'd2, 4'd9, 32'h99);
        expect_bcast(2'd3, 4'd10, 32'hD1D1);
        expect_bcast(2'd3, 4'd11, 32'hD2D2);
        step();
        fu_valid = 4'b1000; fu_tag[3] = 4'd11; fu_data[3] = 32'hD2D2;
        check("bp_ready_low", 64'(fu_ready[3]), 64'd0);
        check("bp_buf_tag", 64'(dut.buf_q[3].tag), 64'd10);
        check("bp_buf_data", 64'(dut.buf_q[3].data), 64'hD1D1);
        step();
        check("bp_hold_data", 64'(dut.buf_q[3].data), 64'hD1D1);
        check("bp_ready_on_grant", 64'(fu_ready[3]), 64'd1);
        step();
        fu_valid = '0;
        check("bp_refill_tag", 64'(dut.buf_q[3].tag), 64'd11);
        step();
        step();
        check("bp_idle", 64'(cdb_valid), 64'd0);

        // Flush with buffers 0 and 1 full; FU2 handshake in flush cycle dropped
        fu_valid = 4'b0011;
        fu_tag[0] = 4'd12; fu_data[0] = 32'hC0;
        fu_tag[1] = 4'd13; fu_data[1] = 32'hC1;
        step();
        fu_valid = 4'b0100; fu_tag[2] = 4'd14; fu_data[2] = 32'hE0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_no_bcast", 64'(cdb_valid), 64'd0);
        check("flush_ready", 64'(fu_ready), 64'hF);
        check("flush_full", 64'(dut.full_q), 64'd0);
        check("flush_ptr", 64'(dut.rr_ptr_q), 64'd0);
        fu_valid = 4'b0100; fu_tag[2] = 4'd15; fu_data[2] = 32'hF00D;
        expect_bcast(2'd2, 4'd15, 32'hF00D);
        step();
        fu_valid = '0;
        check("postflush_no_early", 64'(cdb_valid), 64'd0);
        step();
        check("postflush_bcast", 64'(cdb_valid), 64'd1);
        step();

        // Reset in the middle of draining four buffered results (rr_ptr=3)
        fu_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i]  = 4'(i + 1);
            fu_data[i] = 32'h300 + 32'(i);
        end
        expect_bcast(2'd3, 4'd4, 32'h303);
        step();
        fu_valid = '0;
        step();
        #5 rst = 1'b1;
        #1;
        check("midrst_valid", 64'(cdb_valid), 64'd0);
        check("midrst_outs", 64'({cdb_src, cdb_tag, cdb_data}), 64'd0);
        check("midrst_ready", 64'(fu_ready), 64'hF);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_bcast", 64'(cdb_valid), 64'd0);
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Producer end of the common data bus (CDB).
- Collects completed results from NUM_FU functional units through valid/ready handshakes and buffers one result per unit.
- Round-robin arbitrates among buffered results and broadcasts one (tag, data) per cycle on a registered CDB.
- The CDB feeds the reservation stations and reorder buffer that the instruction queue dispatches into.

Parameters:
- NUM_FU, 4, number of functional-unit result ports (2..8).
- TAG_W, 4, ROB tag width.
- DATA_W, 32, result data width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- flush_in  input  1  mispredict flush; synchronous, drops all pending results.
- fu_valid_in  input  NUM_FU  per-FU result valid.
- fu_tag_in  input  NUM_FU x TAG_W  per-FU ROB tag.
- fu_data_in  input  NUM_FU x DATA_W  per-FU result value.
- fu_ready_out  output  NUM_FU  per-FU buffer can accept.
- cdb_valid_out  output  1  broadcast valid.
- cdb_tag_out  output  TAG_W  broadcast ROB tag.
- cdb_data_out  output  DATA_W  broadcast value.
- cdb_src_out  output  $clog2(NUM_FU)  index of the winning FU.

Behaviour:
- Reset (async, rst_in=1):
  - All buffer full flags = 0, rr_ptr = 0.
  - cdb_valid_out = 0; cdb_tag_out, cdb_data_out and cdb_src_out = 0.
  - fu_ready_out is all-ones once reset deasserts.
  - Reset mid-operation discards every buffered and in-flight result.
- Per-FU holding buffer: one entry {full, tag, data}.
- Arbitration (combinational, from registered full flags):
  - Scan the full buffers starting at index rr_ptr, wrapping modulo NUM_FU.
  - The first full buffer found is grant[i].
  - At most one grant per cycle.
- fu_ready_out[i] = !full[i] | grant[i]. Same-cycle drain and refill is allowed, giving one result per FU per cycle of throughput.
- Accept: fu_valid_in[i] & fu_ready_out[i] at a rising edge loads the buffer and sets full[i].
- Grant edge:
  - Winner's tag and data are registered onto the CDB outputs, and cdb_src_out = winner index.
  - cdb_valid_out = 1.
  - full[winner] clears, unless it is refilled on the same edge.
  - rr_ptr = (winner+1) mod NUM_FU.
- No grant: cdb_valid_out = 0 the next cycle, and the other outputs hold their last values.
- Latency: a handshake at edge k appears on the CDB in the cycle after edge k+1, at the earliest.
- Fairness: a full buffer waits at most NUM_FU-1 grants.
- FU protocol:
  - While fu_valid_in is high and fu_ready_out is low, the FU holds tag and data stable.
  - The block never drops an accepted result except on flush or reset.
- flush_in=1 at an edge:
  - All full flags clear.
  - cdb_valid_out = 0 next cycle.
  - Handshakes occurring in the flush cycle are discarded.
  - The grant in the flush cycle is suppressed: no broadcast, and rr_ptr is unchanged.
- No two buffers hold the same tag; the bench must not violate this, and the block does not check it.

Decomposition:
- Package cdb_pkg:
  - cdb_entry_t struct {tag, data}, sized from package constants TAG_W and DATA_W.
  - Default parameter constants.
- Sub-module rr_arbiter:
  - Inputs: req[NUM_FU], ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; reused by the issue-select logic.
- cdb_broadcaster holds the buffers, rr_ptr and the output registers.

Test Plan:
- Reset then idle:
  - Assert rst_in mid-cycle.
  - Required: cdb_valid_out=0 immediately and all outputs 0.
  - After deassert: fu_ready_out=4'b1111.
- Single result:
  - FU1 presents tag=3, data=32'h0000_0005 (addi a1,a1,1 result) for one edge.
  - Required: the next cycle has no broadcast; the following cycle has cdb_valid_out=1, cdb_tag_out=3, cdb_data_out=5, cdb_src_out=1.
  - Required: rr_ptr=2.
- All four FUs valid at once (tags 0..3), rr_ptr=0:
  - Required: broadcasts on four consecutive cycles in order src 0,1,2,3.
  - Required: FU0 ready immediately refills.
- Continuous contention: FU0 and FU2 valid every cycle for 20 cycles.
  - Required: grants strictly alternate 0,2,0,2.
  - Required: every accepted tag broadcast exactly once; none lost or duplicated (scoreboard).
- Backpressure: FU3 keeps valid high while full and not granted.
  - Required: fu_ready_out[3]=0 and the buffer contents are unchanged until the grant.
  - Required: the held data is the value broadcast.
- Flush: fill buffers 0 and 1, assert flush_in for one cycle.
  - Required: no broadcast of either tag.
  - Required: fu_ready_out=4'b1111 the next cycle.
  - Required: a new FU2 result after the flush broadcasts normally.
